// File: rtl/requant_gelu_feed.sv
// Requantizes signed 32-bit matmul accumulators to int8 for the GELU stage.
// Three-stage pipeline (bias add, multiply, round/shift/saturate) with a global stall.
module requant_gelu_feed (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] acc_in,
    input  logic [31:0] bias,
    input  logic [15:0] mult,
    input  logic [5:0]  shift,
    input  logic [2:0]  out_scale,
    input  logic        acc_valid,
    output logic        acc_ready,
    output logic [7:0]  x,
    output logic [2:0]  in_scale,
    output logic        x_valid,
    input  logic        x_ready,
    output logic [15:0] sat_cnt
);

    // Handshake: a beat moves on either side only when valid & ready are both
    // high at a rising edge; while x_valid & ~x_ready every stage register holds.

    // S1: bias add
    logic               r_v1;
    logic [32:0]        r_s1;
    logic [15:0]        r_mult1;
    logic [5:0]         r_sh1;
    logic [2:0]         r_os1;
    // S2: multiply
    logic               r_v2;
    logic [48:0]        r_p2;
    logic [5:0]         r_sh2;
    logic [2:0]         r_os2;
    // S3: output registers
    logic               r_v3;
    logic [7:0]         r_x;
    logic [2:0]         r_os3;
    logic               r_clip;
    logic [15:0]        r_sat;

    logic               w_stall;
    logic [5:0]         w_sh_in;
    logic [32:0]        w_sum;
    logic [48:0]        w_s_ext;
    logic [48:0]        w_m_ext;
    logic [48:0]        w_prod;
    logic signed [49:0] w_round;
    logic signed [49:0] w_shifted;
    logic               w_hi;
    logic               w_lo;
    logic [7:0]         w_sat;

    assign w_stall   = r_v3 & ~x_ready;
    assign acc_ready = ~w_stall;
    assign x_valid   = r_v3;
    assign x         = r_x;
    assign in_scale  = r_os3;
    assign sat_cnt   = r_sat;

    assign w_sh_in = (shift > 6'd47) ? 6'd47 : shift;
    assign w_sum   = {acc_in[31], acc_in} + {bias[31], bias};

    // Modular 49-bit product of the sign-extended sum and zero-extended multiplier.
    assign w_s_ext = {{16{r_s1[32]}}, r_s1};
    assign w_m_ext = {33'd0, r_mult1};
    assign w_prod  = w_s_ext * w_m_ext;

    // One extra bit of headroom so the rounding constant cannot overflow.
    assign w_round   = {r_p2[48], r_p2} +
                       ((r_sh2 == 6'd0) ? 50'd0 : (50'd1 << (r_sh2 - 6'd1)));
    assign w_shifted = w_round >>> r_sh2;
    assign w_hi      = (w_shifted > 50'sd127);
    assign w_lo      = (w_shifted < -50'sd128);
    assign w_sat     = w_hi ? 8'h7F : (w_lo ? 8'h80 : w_shifted[7:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_s1    <= '0;
            r_mult1 <= '0;
            r_sh1   <= '0;
            r_os1   <= '0;
            r_v2    <= 1'b0;
            r_p2    <= '0;
            r_sh2   <= '0;
            r_os2   <= '0;
            r_v3    <= 1'b0;
            r_x     <= '0;
            r_os3   <= '0;
            r_clip  <= 1'b0;
            r_sat   <= '0;
        end else begin
            if (r_v3 && x_ready && r_clip && (r_sat != 16'hFFFF))
                r_sat <= r_sat + 16'd1;
            if (!w_stall) begin
                // Data registers load only behind a valid beat so bubbles leave them untouched.
                r_v1 <= acc_valid;
                if (acc_valid) begin
                    r_s1    <= w_sum;
                    r_mult1 <= mult;
                    r_sh1   <= w_sh_in;
                    r_os1   <= out_scale;
                end
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_p2  <= w_prod;
                    r_sh2 <= r_sh1;
                    r_os2 <= r_os1;
                end
                r_v3 <= r_v2;
                if (r_v2) begin
                    r_x    <= w_sat;
                    r_clip <= w_hi | w_lo;
                    r_os3  <= r_os2;
                end
            end
        end
    end

endmodule

// File: tb/tb_requant_gelu_feed.sv
// Bench for requant_gelu_feed: directed rounding, saturation, backpressure,
// per-beat config and reset steps, then a randomized scoreboarded stream.
module tb_requant_gelu_feed;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] acc_in;
    logic [31:0] bias;
    logic [15:0] mult;
    logic [5:0]  shift;
    logic [2:0]  out_scale;
    logic        acc_valid;
    logic        acc_ready;
    logic [7:0]  x;
    logic [2:0]  in_scale;
    logic        x_valid;
    logic        x_ready;
    logic [15:0] sat_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] exp_q[$];
    int          m_sat = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_x = '0;
    logic [2:0]  prev_s = '0;

    always #5 clk = ~clk;

    requant_gelu_feed dut (
        .clk(clk), .rst(rst), .acc_in(acc_in), .bias(bias), .mult(mult),
        .shift(shift), .out_scale(out_scale), .acc_valid(acc_valid),
        .acc_ready(acc_ready), .x(x), .in_scale(in_scale), .x_valid(x_valid),
        .x_ready(x_ready), .sat_cnt(sat_cnt)
    );

    // Reference: {clipped, out_scale, int8 result} from plain integer arithmetic.
    function automatic logic [11:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [15:0] m, input logic [5:0] sh,
                                          input logic [2:0] os);
        longint s, p, r;
        int     k;
        logic   c;
        logic [7:0] xv;
        s = longint'($signed(a)) + longint'($signed(b));
        p = s * longint'(m);
        k = (sh > 6'd47) ? 47 : int'(sh);
        if (k == 0) r = p;
        else        r = (p + (longint'(1) <<< (k - 1))) >>> k;
        c  = (r > 127) || (r < -128);
        xv = (r > 127) ? 8'h7F : ((r < -128) ? 8'h80 : r[7:0]);
        return {c, os, xv};
    endfunction

    task automatic chk8(input logic [7:0] obs, input logic [7:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input logic [15:0] obs, input logic [15:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [15:0] m,
                         input logic [5:0] sh, input logic [2:0] os);
        acc_in = a; bias = b; mult = m; shift = sh; out_scale = os; acc_valid = 1'b1;
    endtask

    // Single beat with x_ready high: result is visible just after the third edge.
    task automatic run_beat(input logic [31:0] a, input logic [31:0] b, input logic [15:0] m,
                            input logic [5:0] sh, input logic [2:0] os,
                            input logic [7:0] ex, input logic [2:0] es, input string tag);
        drive(a, b, m, sh, os);
        @(posedge clk); #1 acc_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk8(8'(x_valid), 8'd1, {tag, "_valid"});
        chk8(x, ex, {tag, "_x"});
        chk8(8'(in_scale), 8'(es), {tag, "_scale"});
    endtask

    // Scoreboard / protocol monitor, sampled mid-cycle while inputs are stable.
    always @(negedge clk) begin
        logic [11:0] e;
        if (rst) begin
            exp_q.delete();
            m_sat      = 0;
            prev_stall = 1'b0;
        end else begin
            chk8(8'(acc_ready), 8'(!(x_valid && !x_ready)), "mon_acc_ready");
            chk16(sat_cnt, 16'(m_sat), "mon_sat_cnt");
            if (prev_stall) begin
                chk8(8'(x_valid), 8'd1, "mon_hold_valid");
                chk8(x, prev_x, "mon_hold_x");
                chk8(8'(in_scale), 8'(prev_s), "mon_hold_scale");
            end
            if (acc_valid && acc_ready)
                exp_q.push_back(model(acc_in, bias, mult, shift, out_scale));
            if (x_valid && x_ready) begin
                checks++;
                assert (exp_q.size() > 0) else begin
                    errors++;
                    $error("FAIL mon_unexpected_beat observed=%0h expected=none", x);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk8(x, e[7:0], "mon_x");
                    chk8(8'(in_scale), 8'(e[10:8]), "mon_scale");
                    if (e[11] && m_sat < 65535) m_sat++;
                end
            end
            prev_stall = x_valid && !x_ready;
            prev_x     = x;
            prev_s     = in_scale;
        end
    end

    initial begin
        int         sent;
        int         acc_cnt;
        int         cyc;
        logic [7:0] got[$];

        rst = 1'b1; acc_valid = 1'b0; x_ready = 1'b1;
        acc_in = '0; bias = '0; mult = '0; shift = '0; out_scale = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk8(8'(x_valid), 8'd0, "rst_x_valid");
        chk8(x, 8'd0, "rst_x");
        chk8(8'(in_scale), 8'd0, "rst_in_scale");
        chk16(sat_cnt, 16'd0, "rst_sat_cnt");
        chk8(8'(acc_ready), 8'd1, "rst_acc_ready");

        // Rounding
        run_beat(32'd10, 32'd0, 16'd1, 6'd2, 3'd0, 8'd3, 3'd0, "round_pos");
        run_beat(-32'sd10, 32'd0, 16'd1, 6'd2, 3'd0, 8'hFE, 3'd0, "round_neg");
        run_beat(32'd100, 32'd0, 16'd3, 6'd2, 3'd5, 8'd75, 3'd5, "round_mult");

        // Saturation
        run_beat(32'd100000, 32'd0, 16'd1, 6'd0, 3'd0, 8'h7F, 3'd0, "sat_hi");
        @(posedge clk); #1 chk16(sat_cnt, 16'd1, "sat_cnt_1");
        run_beat(-32'sd100000, 32'd0, 16'd1, 6'd0, 3'd0, 8'h80, 3'd0, "sat_lo");
        @(posedge clk); #1 chk16(sat_cnt, 16'd2, "sat_cnt_2");
        run_beat(32'd5, 32'd0, 16'd1, 6'd0, 3'd0, 8'd5, 3'd0, "sat_none");
        @(posedge clk); #1 chk16(sat_cnt, 16'd2, "sat_cnt_2b");

        // Backpressure: beats 1..6, x_ready low for cycles 4..8
        sent = 0;
        for (int c = 0; c < 20; c++) begin
            x_ready = !(c >= 4 && c <= 8);
            if (sent < 6) drive(32'(sent + 1), 32'd0, 16'd1, 6'd0, 3'd0);
            else          acc_valid = 1'b0;
            #1;
            if (c >= 4 && c <= 8) chk8(8'(acc_ready), 8'd0, "bp_acc_ready_low");
            if (x_valid && x_ready) got.push_back(x);
            if (acc_valid && acc_ready) sent++;
            @(posedge clk); #1;
        end
        acc_valid = 1'b0; x_ready = 1'b1;
        chk16(16'(got.size()), 16'd6, "bp_count");
        for (int i = 0; i < got.size() && i < 6; i++)
            chk8(got[i], 8'(i + 1), "bp_order");

        // Per-beat config
        drive(32'd8, 32'd0, 16'd1, 6'd1, 3'd2);
        @(posedge clk); #1 drive(32'd8, 32'd0, 16'd1, 6'd0, 3'd6);
        @(posedge clk); #1 acc_valid = 1'b0;
        @(posedge clk); #1;
        chk8(x, 8'd4, "cfg_a_x");
        chk8(8'(in_scale), 8'd2, "cfg_a_scale");
        @(posedge clk); #1;
        chk8(x, 8'd8, "cfg_b_x");
        chk8(8'(in_scale), 8'd6, "cfg_b_scale");

        // Reset mid-stream with three beats in flight and a beat offered during reset
        for (int i = 0; i < 3; i++) begin
            drive(32'd1000, 32'd0, 16'd1, 6'd0, 3'd1);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        drive(32'd7, 32'd0, 16'd1, 6'd0, 3'd3);
        @(posedge clk); #1 rst = 1'b0; acc_valid = 1'b0;
        chk8(8'(x_valid), 8'd0, "mrst_x_valid");
        chk16(sat_cnt, 16'd0, "mrst_sat_cnt");
        chk8(8'(acc_ready), 8'd1, "mrst_acc_ready");
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk8(8'(x_valid), 8'd0, "mrst_no_stale");
        end

        // Randomized stream
        acc_cnt = 0; cyc = 0;
        while (acc_cnt < 1000 && cyc < 20000) begin
            x_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) != 0) begin
                case ($urandom_range(0, 2))
                    0: drive(32'($urandom_range(0, 600)) - 32'd300,
                             32'($urandom_range(0, 200)) - 32'd100,
                             16'($urandom_range(0, 4)), 6'($urandom_range(0, 3)),
                             3'($urandom_range(0, 7)));
                    1: drive(32'($urandom_range(0, 65535)) - 32'd32768,
                             32'($urandom_range(0, 65535)) - 32'd32768,
                             16'($urandom), 6'($urandom_range(10, 30)),
                             3'($urandom_range(0, 7)));
                    default: drive($urandom, $urandom, 16'($urandom),
                                   6'($urandom_range(0, 63)), 3'($urandom_range(0, 7)));
                endcase
            end else begin
                acc_valid = 1'b0;
            end
            #1;
            if (acc_valid && acc_ready) acc_cnt++;
            @(posedge clk); #1;
            cyc++;
        end
        chk16(16'(acc_cnt), 16'd1000, "stream_accepted");
        acc_valid = 1'b0; x_ready = 1'b1; cyc = 0;
        while (exp_q.size() > 0 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk16(16'(exp_q.size()), 16'd0, "stream_drained");
        repeat (2) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/requant_gelu_feed.md
REQUANT_GELU_FEED -- requirements
Module: requant_gelu_feed

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous reset, active-high; sampled on the rising edge of clk.
REQ-003 acc_in  input  32  signed matmul accumulator beat.
REQ-004 bias  input  32  signed bias, sampled with acc_in.
REQ-005 mult  input  16  unsigned requant multiplier, sampled with acc_in.
REQ-006 shift  input  6  right-shift amount 0..47, sampled with acc_in; values >47 are treated as 47.
REQ-007 out_scale  input  3  fractional-bit count of output, sampled with acc_in; passed through unchanged.
REQ-008 acc_valid  input  1  upstream beat valid.
REQ-009 acc_ready  output  1  block accepts beat when acc_valid & acc_ready.
REQ-010 x  output  8  signed int8 result; feeds GELU x port.
REQ-011 in_scale  output  3  out_scale of the beat on x; feeds GELU in_scale port.
REQ-012 x_valid  output  1  x/in_scale hold a valid beat.
REQ-013 x_ready  input  1  downstream accepts beat when x_valid & x_ready.
REQ-014 sat_cnt  output  16  count of saturated output beats.

Function
REQ-015 Pipeline SHALL be 3 stages: S1 bias add, S2 multiply, S3 round/shift/saturate; each stage holds a valid bit plus a copy of shift and out_scale.
REQ-016 S1 SHALL compute s = acc_in + bias at 33-bit signed width, with no overflow possible.
REQ-017 S2 SHALL compute p = s * mult at 49-bit signed width, with mult zero-extended.
REQ-018 S3 SHALL compute r = (p + 2^(shift-1)) >>> shift when shift>0, and r = p when shift=0; this is round-half-up toward +inf, arithmetic shift.
REQ-019 S3 SHALL saturate r to [-128,127] and drive the result on x.
REQ-020 Latency SHALL be 3 cycles from acceptance to x_valid when unstalled.
REQ-021 Throughput SHALL be 1 beat/cycle when x_ready is held high.
REQ-022 stall = x_valid & ~x_ready; while stall is high, all stage registers SHALL hold.
REQ-023 acc_ready SHALL equal ~stall, combinationally.
REQ-024 When unstalled, each stage SHALL advance; bubbles (valid=0) propagate, and an empty S3 does not block upstream.
REQ-025 x and in_scale SHALL remain stable while x_valid & ~x_ready.
REQ-026 Config inputs (bias, mult, shift, out_scale) SHALL be captured per accepted beat; a config change between beats affects only later beats.
REQ-027 Beat order SHALL be preserved, with no loss or duplication under any x_ready pattern.
REQ-028 sat_cnt SHALL increment by 1 on each output handshake (x_valid & x_ready) whose beat was clipped, and SHALL stick at 16'hFFFF.
REQ-029 acc_valid=0 SHALL insert a bubble and SHALL NOT alter any stage's data.

Reset
REQ-030 On rst=1: all stage valid bits SHALL be 0, x_valid=0, x=0, in_scale=0, sat_cnt=0, and acc_ready=1 on the following cycle.
REQ-031 Reset mid-stream SHALL discard all in-flight beats; no beat accepted before reset appears after it.
REQ-032 A beat presented with acc_valid during the rst cycle SHALL NOT be accepted.

Verification
REQ-033 Rounding: acc_in=10, bias=0, mult=1, shift=2 -> x=3 after 3 cycles; acc_in=-10 -> x=-2; acc_in=100, mult=3, shift=2 -> x=75; out_scale=5 -> in_scale=5.
REQ-034 Saturation: acc_in=100000, mult=1, shift=0 -> x=127, sat_cnt=1; then acc_in=-100000 -> x=-128, sat_cnt=2; then acc_in=5 -> x=5, sat_cnt=2.
REQ-035 Backpressure: 6 consecutive beats 1..6 (mult=1, shift=0) with x_ready low for cycles 4-8 -> acc_ready low while stalled, x holds, and outputs arrive in order 1..6 with none lost.
REQ-036 Per-beat config: beat A with shift=1, out_scale=2, next-cycle beat B with shift=0, out_scale=6, both acc_in=8 -> A gives x=4, in_scale=2; B gives x=8, in_scale=6.
REQ-037 Reset mid-stream: rst asserted with 3 beats in flight -> x_valid=0 and sat_cnt=0 next cycle, and no stale beat emerges afterward.
REQ-038 Streaming: 1000 random beats with random x_ready, checked against a reference-model scoreboard -> exact match, sat_cnt equals the model's clip count (capped at 65535).
